// File: rtl/branch_stack_if.sv
// rtl/branch_stack_if.sv - resolve, dispatch and restore bundle for the branch stack
//
// Purpose: carries the branch-resolve inputs, the dispatch checkpoint inputs and
// the recovery outputs between the branch stack and its neighbours.
// Ports (signals):
//   b_mm_resolve          one-hot (or zero) branch resolving this cycle
//   b_mm_mispred          resolving branch was mispredicted
//   branch_stack_entries  per-slot checkpoint offered by dispatch
//   next_b_mask           dispatch's proposed next valid-slot mask
//   b_mask_combinational  valid-slot mask after this cycle's resolve
//   restore_valid         mispredict recovery active this cycle
//   PC_restore            recovery PC
//   rob_tail_restore      ROB tail checkpoint
//   freelist_restore      free-list checkpoint
//   map_table_restore     map-table checkpoint
//   bs_debug              current and next contents of every slot
// Modports: master = resolve/dispatch side, slave = branch stack.
interface branch_stack_if #(
  parameter int B_MASK_WIDTH = 4,
  parameter int ARCH_REG_SZ  = 32,
  parameter int PHYS_REG_SZ  = 64,
  parameter int ROB_SZ_BITS  = 5,
  parameter int ADDR_W       = 32
);
  localparam int PHYS_IDX = $clog2(PHYS_REG_SZ);

  typedef struct packed {
    logic [ADDR_W-1:0]                     recovery_PC;
    logic [B_MASK_WIDTH-1:0]               b_m;
    logic [ROB_SZ_BITS-1:0]                rob_tail;
    logic [PHYS_REG_SZ-1:0]                freelist;
    logic [ARCH_REG_SZ-1:0][PHYS_IDX-1:0]  map_table;
  } entry_t;

  typedef struct packed {
    entry_t [B_MASK_WIDTH-1:0] branch_stack;
    entry_t [B_MASK_WIDTH-1:0] next_branch_stack;
  } debug_t;

  logic [B_MASK_WIDTH-1:0]               b_mm_resolve;
  logic                                  b_mm_mispred;
  entry_t [B_MASK_WIDTH-1:0]             branch_stack_entries;
  logic [B_MASK_WIDTH-1:0]               next_b_mask;
  logic [B_MASK_WIDTH-1:0]               b_mask_combinational;
  logic                                  restore_valid;
  logic [ADDR_W-1:0]                     PC_restore;
  logic [ROB_SZ_BITS-1:0]                rob_tail_restore;
  logic [PHYS_REG_SZ-1:0]                freelist_restore;
  logic [ARCH_REG_SZ-1:0][PHYS_IDX-1:0]  map_table_restore;
  debug_t                                bs_debug;

  modport master (
    output b_mm_resolve, b_mm_mispred, branch_stack_entries, next_b_mask,
    input  b_mask_combinational, restore_valid, PC_restore, rob_tail_restore,
    input  freelist_restore, map_table_restore, bs_debug
  );

  modport slave (
    input  b_mm_resolve, b_mm_mispred, branch_stack_entries, next_b_mask,
    output b_mask_combinational, restore_valid, PC_restore, rob_tail_restore,
    output freelist_restore, map_table_restore, bs_debug
  );
endinterface

// File: rtl/branch_stack.sv
// rtl/branch_stack.sv - branch checkpoint stack with resolve and mispredict recovery
//
// Purpose: holds one rename/ROB checkpoint per in-flight branch. A correct
// resolve frees the branch's slot and drops it from every dependency mask; a
// mispredict replays the slot's checkpoint on the restore outputs in the same
// cycle and squashes the branch together with everything younger.
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous active-low reset
//   bs     branch_stack_if slave (resolve/dispatch inputs, restore outputs, debug)
module branch_stack #(
  parameter int B_MASK_WIDTH = 4,
  parameter int ARCH_REG_SZ  = 32,
  parameter int PHYS_REG_SZ  = 64,
  parameter int ROB_SZ_BITS  = 5,
  parameter int ADDR_W       = 32
) (
  input  logic          clock,
  input  logic          reset,
  branch_stack_if.slave bs
);
  localparam int PHYS_IDX = $clog2(PHYS_REG_SZ);
  localparam int IDX_W    = (B_MASK_WIDTH > 1) ? $clog2(B_MASK_WIDTH) : 1;

  // Same bit layout as the interface entry type, so whole-packet assignments
  // across the port are plain vector copies.
  typedef struct packed {
    logic [ADDR_W-1:0]                     recovery_PC;
    logic [B_MASK_WIDTH-1:0]               b_m;
    logic [ROB_SZ_BITS-1:0]                rob_tail;
    logic [PHYS_REG_SZ-1:0]                freelist;
    logic [ARCH_REG_SZ-1:0][PHYS_IDX-1:0]  map_table;
  } packet_t;

  logic [B_MASK_WIDTH-1:0]   b_mask;
  packet_t [B_MASK_WIDTH-1:0] branch_stack;
  packet_t [B_MASK_WIDTH-1:0] next_branch_stack;
  packet_t [B_MASK_WIDTH-1:0] entries;

  logic [B_MASK_WIDTH-1:0] hit_vec;
  logic                    hit;
  logic [IDX_W-1:0]        idx;
  packet_t                 sel;
  logic                    restore_valid;
  logic [B_MASK_WIDTH-1:0] b_mask_comb;
  logic [B_MASK_WIDTH-1:0] idx_clear;

  assign entries = bs.branch_stack_entries;

  // A resolve only counts when it names a slot that is actually live.
  assign hit_vec = bs.b_mm_resolve & b_mask;
  assign hit     = |hit_vec;

  // Resolve is one-hot; the lowest set bit wins if it is ever not.
  always_comb begin
    idx = '0;
    for (int i = B_MASK_WIDTH - 1; i >= 0; i--) begin
      if (hit_vec[i]) idx = IDX_W'(i);
    end
  end

  assign sel           = branch_stack[idx];
  assign restore_valid = hit & bs.b_mm_mispred;
  assign idx_clear     = ~(B_MASK_WIDTH'(1) << idx);

  // On a mispredict the branch's own dependency mask is exactly the set of
  // older branches that survive, so it becomes the new valid mask.
  always_comb begin
    b_mask_comb = b_mask;
    if (restore_valid) begin
      b_mask_comb = sel.b_m;
    end else if (hit) begin
      b_mask_comb = b_mask & ~bs.b_mm_resolve;
    end
  end

  // Dispatch may only write a slot that is free after this cycle's resolve,
  // which lets a slot freed by a correct resolve be reused in the same cycle.
  // The resolved bit is cleared after the writes so that a checkpoint
  // dispatched in the same cycle never depends on an already-resolved branch.
  always_comb begin
    next_branch_stack = branch_stack;
    if (!restore_valid) begin
      for (int i = 0; i < B_MASK_WIDTH; i++) begin
        if (bs.next_b_mask[i] && !b_mask_comb[i]) begin
          next_branch_stack[i] = entries[i];
        end
      end
      if (hit) begin
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
          next_branch_stack[i].b_m = next_branch_stack[i].b_m & idx_clear;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_mask       <= '0;
      branch_stack <= '0;
    end else begin
      b_mask       <= restore_valid ? b_mask_comb : bs.next_b_mask;
      branch_stack <= next_branch_stack;
    end
  end

  assign bs.b_mask_combinational = b_mask_comb;
  assign bs.restore_valid        = restore_valid;
  assign bs.PC_restore           = restore_valid ? sel.recovery_PC : '0;
  assign bs.rob_tail_restore     = restore_valid ? sel.rob_tail    : '0;
  assign bs.freelist_restore     = restore_valid ? sel.freelist    : '0;
  assign bs.map_table_restore    = restore_valid ? sel.map_table   : '0;
  assign bs.bs_debug             = {branch_stack, next_branch_stack};
endmodule

// File: tb/tb_branch_stack.sv
// tb/tb_branch_stack.sv - self-checking bench for branch_stack
module tb_branch_stack;
  localparam int B    = 4;
  localparam int ARCH = 32;
  localparam int PHYS = 64;
  localparam int ROBB = 5;
  localparam int AW   = 32;
  localparam int PIDX = 6;

  typedef struct packed {
    logic [AW-1:0]                 recovery_PC;
    logic [B-1:0]                  b_m;
    logic [ROBB-1:0]               rob_tail;
    logic [PHYS-1:0]               freelist;
    logic [ARCH-1:0][PIDX-1:0]     map_table;
  } entry_t;

  typedef struct {
    logic [B-1:0] resolve;
    logic         mispred;
    logic [B-1:0] nbm;
    int           new_slot;
    logic [B-1:0] exp_bmc;
    logic         exp_rv;
  } vec_t;

  typedef struct {
    logic [B-1:0]              bmc;
    logic                      rv;
    logic [AW-1:0]             pc;
    logic [ROBB-1:0]           rob;
    logic [PHYS-1:0]           fl;
    logic [ARCH-1:0][PIDX-1:0] map;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  branch_stack_if #(.B_MASK_WIDTH(B), .ARCH_REG_SZ(ARCH), .PHYS_REG_SZ(PHYS),
                    .ROB_SZ_BITS(ROBB), .ADDR_W(AW)) bs_if ();

  branch_stack #(.B_MASK_WIDTH(B), .ARCH_REG_SZ(ARCH), .PHYS_REG_SZ(PHYS),
                 .ROB_SZ_BITS(ROBB), .ADDR_W(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bs    (bs_if)
  );

  entry_t [B-1:0] drv;
  assign bs_if.branch_stack_entries = drv;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  entry_t fill [B];
  entry_t junk [B];
  entry_t newent, ent_a, ent_b, ent_c, slot3_exp;
  entry_t zero_ent;
  vec_t tbl [4];

  function automatic entry_t rnd(input logic [B-1:0] bm);
    entry_t e;
    e.recovery_PC = $urandom;
    e.b_m         = bm;
    e.rob_tail    = ROBB'($urandom);
    e.freelist    = {$urandom, $urandom};
    for (int k = 0; k < ARCH; k++) e.map_table[k] = PIDX'($urandom);
    return e;
  endfunction

  task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic slot_check(input string name, input int s, input entry_t exp);
    check($sformatf("%s_slot%0d", name, s), 300'(bs_if.bs_debug.branch_stack[s]), 300'(exp));
  endtask

  // Drive one cycle of resolve/dispatch, queue the expectation, then compare
  // the combinational outputs mid-cycle. Caller is at a negedge.
  task automatic drive_and_check(input string name, input logic [B-1:0] res, input logic mp,
                                 input logic [B-1:0] nbm, input logic [B-1:0] exp_bmc,
                                 input logic exp_rv, input entry_t re);
    exp_t e;
    exp_t got;
    bs_if.b_mm_resolve = res;
    bs_if.b_mm_mispred = mp;
    bs_if.next_b_mask  = nbm;
    e.bmc = exp_bmc;
    e.rv  = exp_rv;
    e.pc  = exp_rv ? re.recovery_PC : '0;
    e.rob = exp_rv ? re.rob_tail    : '0;
    e.fl  = exp_rv ? re.freelist    : '0;
    e.map = exp_rv ? re.map_table   : '0;
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    check({name, "_bmc"}, 300'(bs_if.b_mask_combinational), 300'(got.bmc));
    check({name, "_rv"},  300'(bs_if.restore_valid),        300'(got.rv));
    check({name, "_pc"},  300'(bs_if.PC_restore),           300'(got.pc));
    check({name, "_rob"}, 300'(bs_if.rob_tail_restore),     300'(got.rob));
    check({name, "_fl"},  300'(bs_if.freelist_restore),     300'(got.fl));
    check({name, "_map"}, 300'(bs_if.map_table_restore),    300'(got.map));
  endtask

  initial begin
    zero_ent = '0;
    fill[0] = rnd(4'b0000);
    fill[1] = rnd(4'b0001);
    fill[2] = rnd(4'b0011);
    fill[3] = rnd(4'b0111);
    for (int i = 0; i < B; i++) junk[i] = rnd(4'b0000);
    newent = rnd(4'b0011);

    //           resolve  mp    nbm      slot exp_bmc  rv
    tbl[0] = '{4'b0000, 1'b1, 4'b1111, -1, 4'b1111, 1'b0};  // null mispredict
    tbl[1] = '{4'b0100, 1'b0, 4'b1011, -1, 4'b1011, 1'b0};  // correct resolve of slot 2
    tbl[2] = '{4'b0100, 1'b1, 4'b1011, -1, 4'b1011, 1'b0};  // resolve of a dead slot
    tbl[3] = '{4'b0000, 1'b0, 4'b1111,  2, 4'b1011, 1'b0};  // refill slot 2 only

    // Reset state, with a would-be mispredict held on the inputs.
    for (int i = 0; i < B; i++) drv[i] = fill[i];
    bs_if.b_mm_resolve = 4'b0001;
    bs_if.b_mm_mispred = 1'b1;
    bs_if.next_b_mask  = 4'b1111;
    #12;
    check("reset_bmc", 300'(bs_if.b_mask_combinational), 300'(0));
    check("reset_rv",  300'(bs_if.restore_valid), 300'(0));
    check("reset_pc",  300'(bs_if.PC_restore), 300'(0));
    for (int i = 0; i < B; i++) slot_check("reset", i, zero_ent);

    // Fill every slot in one edge.
    @(negedge clock);
    reset = 1'b1;
    bs_if.b_mm_resolve = 4'b0000;
    bs_if.b_mm_mispred = 1'b0;
    bs_if.next_b_mask  = 4'b1111;
    @(negedge clock);
    check("fill_bmask", 300'(bs_if.b_mask_combinational), 300'(4'b1111));
    for (int i = 0; i < B; i++) slot_check("fill", i, fill[i]);

    // Table-driven cycles from the full stack; non-target inputs carry junk.
    for (int i = 0; i < B; i++) drv[i] = junk[i];
    for (int r = 0; r < 4; r++) begin
      if (tbl[r].new_slot >= 0) drv[tbl[r].new_slot] = newent;
      drive_and_check($sformatf("row%0d", r), tbl[r].resolve, tbl[r].mispred, tbl[r].nbm,
                      tbl[r].exp_bmc, tbl[r].exp_rv, zero_ent);
      @(negedge clock);
      if (tbl[r].new_slot >= 0) drv[tbl[r].new_slot] = junk[tbl[r].new_slot];
    end

    // Stack after resolve of slot 2 and refill of slot 2.
    bs_if.b_mm_resolve = 4'b0000;
    bs_if.b_mm_mispred = 1'b0;
    #1;
    check("refill_bmask", 300'(bs_if.b_mask_combinational), 300'(4'b1111));
    slot3_exp = fill[3];
    slot3_exp.b_m = 4'b0011;
    slot_check("refill", 0, fill[0]);
    slot_check("refill", 1, fill[1]);
    slot_check("refill", 2, newent);
    slot_check("refill", 3, slot3_exp);

    // Mispredict of slot 1; dispatch's full mask must be ignored.
    @(negedge clock);
    drive_and_check("mispred", 4'b0010, 1'b1, 4'b1111, 4'b0001, 1'b1, fill[1]);
    @(negedge clock);
    drive_and_check("post_mispred", 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b0, zero_ent);

    // Correct resolve of slot 0 while dispatch reuses it in the same cycle.
    ent_a = rnd(4'b0000);
    ent_b = rnd(4'b0000);
    drv[0] = ent_a;
    drv[1] = ent_b;
    @(negedge clock);
    drive_and_check("reuse", 4'b0001, 1'b0, 4'b0011, 4'b0000, 1'b0, zero_ent);
    @(negedge clock);
    drive_and_check("post_reuse", 4'b0000, 1'b0, 4'b0011, 4'b0011, 1'b0, zero_ent);
    slot_check("reuse", 0, ent_a);
    slot_check("reuse", 1, ent_b);

    // Reset between edges discards everything at once.
    @(negedge clock);
    #2;
    bs_if.b_mm_resolve = 4'b0001;
    bs_if.b_mm_mispred = 1'b1;
    reset = 1'b0;
    #1;
    check("midreset_bmc", 300'(bs_if.b_mask_combinational), 300'(0));
    check("midreset_rv",  300'(bs_if.restore_valid), 300'(0));
    for (int i = 0; i < B; i++) slot_check("midreset", i, zero_ent);

    // First edge after release behaves as from empty.
    ent_c = rnd(4'b0000);
    @(negedge clock);
    reset = 1'b1;
    drv[0] = ent_c;
    bs_if.b_mm_resolve = 4'b0000;
    bs_if.b_mm_mispred = 1'b0;
    bs_if.next_b_mask  = 4'b0001;
    @(negedge clock);
    check("release_bmc", 300'(bs_if.b_mask_combinational), 300'(4'b0001));
    slot_check("release", 0, ent_c);
    slot_check("release", 1, zero_ent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
